// File: rtl/diff_seq_unit_if.sv
// diff_seq_unit_if: request/response handshake bundle for diff_seq_unit.
//   master (controller): drives req_valid, a, b, resp_ready; sees req_ready, resp_valid, result
//   slave  (unit)      : the mirror image
interface diff_seq_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output req_valid, a, b, resp_ready,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, a, b, resp_ready,
    output req_ready, resp_valid, result
  );
endinterface

// File: rtl/diff_seq_unit.sv
// diff_seq_unit: multi-cycle DIFF sequencer. Returns the index of the lowest bit where a and b
// differ, or WIDTH when a == b. Scans BITS_PER_CYCLE bits of a^b per clock and stops on the
// first non-zero chunk.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous abort, returns to IDLE and drops any operation/result
//   bus         diff_seq_unit_if.slave (req_valid/req_ready/a/b, resp_valid/resp_ready/result)
//   busy        high in SCAN or DONE
//   perf_ops    completed response handshakes (only with DIFF_SEQ_PERF_EN)
//   perf_cycles edges spent in SCAN           (only with DIFF_SEQ_PERF_EN)
//
// Optional feature macro: DIFF_SEQ_PERF_EN adds the two performance counters.
module diff_seq_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  diff_seq_unit_if.slave       bus,
`ifdef DIFF_SEQ_PERF_EN
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_cycles,
`endif
  output logic                 busy
);

  localparam int unsigned N_CHUNKS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned KW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                r_state, w_state_d;
  logic [WIDTH-1:0]          r_x, w_x_d;
  logic [KW-1:0]             r_k, w_k_d;
  logic [WIDTH-1:0]          r_result, w_result_d;

  logic [BITS_PER_CYCLE-1:0] w_chunk;
  logic [WIDTH-1:0]          w_base;
  logic [WIDTH-1:0]          w_low;
  logic [WIDTH-1:0]          w_hit_idx;
  logic                      w_last;

  // Select the current chunk with constant slices so the mux stays a plain one-hot pick.
  always_comb begin
    w_chunk = '0;
    w_base  = '0;
    for (int unsigned i = 0; i < N_CHUNKS; i++) begin
      if (r_k == KW'(i)) begin
        w_chunk = r_x[i*BITS_PER_CYCLE +: BITS_PER_CYCLE];
        w_base  = WIDTH'(i * BITS_PER_CYCLE);
      end
    end
  end

  // Priority encoder: scanning downwards leaves the lowest set bit as the final winner.
  always_comb begin
    w_low = '0;
    for (int i = int'(BITS_PER_CYCLE) - 1; i >= 0; i--) begin
      if (w_chunk[i]) w_low = WIDTH'(i);
    end
  end

  assign w_hit_idx = w_base + w_low;
  assign w_last    = (r_k == KW'(N_CHUNKS - 1));

  always_comb begin
    w_state_d  = r_state;
    w_x_d      = r_x;
    w_k_d      = r_k;
    w_result_d = r_result;
    if (flush) begin
      // Abort wins over every transition; result is left as it was.
      w_state_d = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            w_x_d     = bus.a ^ bus.b;
            w_k_d     = '0;
            w_state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_chunk != '0) begin
            w_result_d = w_hit_idx;
            w_state_d  = ST_DONE;
          end else if (w_last) begin
            w_result_d = WIDTH'(WIDTH);
            w_state_d  = ST_DONE;
          end else begin
            w_k_d = r_k + KW'(1);
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) w_state_d = ST_IDLE;
        end
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_x      <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_x      <= w_x_d;
      r_k      <= w_k_d;
      r_result <= w_result_d;
    end
  end

  // Outputs decode straight from state so reset takes effect without a clock edge.
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_DONE);
  assign bus.result     = r_result;
  assign busy           = (r_state == ST_SCAN) || (r_state == ST_DONE);

`ifdef DIFF_SEQ_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_ops    <= '0;
      r_perf_cycles <= '0;
    end else begin
      // A flushed DONE cycle drops the result, so it is not a completed handshake.
      if ((r_state == ST_DONE) && bus.resp_ready && !flush) r_perf_ops <= r_perf_ops + 32'd1;
      if (r_state == ST_SCAN) r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign perf_ops    = r_perf_ops;
  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_diff_seq_unit.sv
// tb_diff_seq_unit: directed self-checking bench for diff_seq_unit.
module tb_diff_seq_unit;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
`ifdef DIFF_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_cycles;
`endif

  int checks;
  int failures;
  logic [31:0] last_res;

  diff_seq_unit_if #(.WIDTH(32)) bus_if ();

  diff_seq_unit #(
    .WIDTH          (32),
    .BITS_PER_CYCLE (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus_if),
`ifdef DIFF_SEQ_PERF_EN
    .perf_ops    (perf_ops),
    .perf_cycles (perf_cycles),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_idle(input string name, input logic [31:0] exp_res);
    checks++;
    if (bus_if.req_ready !== 1'b1 || bus_if.resp_valid !== 1'b0 || busy !== 1'b0 ||
        bus_if.result !== exp_res) begin
      failures++;
      $display("FAIL %s: got rdy=%0b vld=%0b busy=%0b res=%0d required rdy=1 vld=0 busy=0 res=%0d",
               name, bus_if.req_ready, bus_if.resp_valid, busy, bus_if.result, exp_res);
    end
  endtask

  // Issue one request, measure latency, optionally hold back-pressure, then hand-shake.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] exp_res,
                        input int exp_lat, input int hold, input string name);
    int lat;
    @(negedge clk);
    bus_if.a = va; bus_if.b = vb; bus_if.req_valid = 1'b1; bus_if.resp_ready = 1'b0;
    checks++;
    if (bus_if.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: got req_ready=%0b required 1", name, bus_if.req_ready);
    end
    @(negedge clk);
    // Operands change after the accept edge; the unit must ignore this.
    bus_if.req_valid = 1'b0; bus_if.a = ~va; bus_if.b = vb ^ 32'h5a5a_0001;
    checks++;
    if (busy !== 1'b1 || bus_if.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: got busy=%0b req_ready=%0b required 1 0", name, busy, bus_if.req_ready);
    end
    lat = 0;
    while (bus_if.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus_if.result !== exp_res) begin
      failures++;
      $display("FAIL %s_result: got %0d required %0d", name, bus_if.result, exp_res);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.resp_valid !== 1'b1 || bus_if.result !== exp_res || bus_if.req_ready !== 1'b0 ||
          busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_hold%0d: got vld=%0b res=%0d rdy=%0b busy=%0b required 1 %0d 0 1",
                 name, i, bus_if.resp_valid, bus_if.result, bus_if.req_ready, busy, exp_res);
      end
    end
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    check_idle({name, "_release"}, exp_res);
    last_res = exp_res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus_if.req_valid = 1'b0; bus_if.resp_ready = 1'b0; bus_if.a = '0; bus_if.b = '0;
    #3;
    check_idle("reset", 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release", 32'd0);
  endtask

  task automatic test_patterns();
    run_op(32'd1, 32'd0, 32'd0, 1, 0, "a1_b0");
    run_op(32'd32768, 32'd32768, 32'd32, 8, 0, "equal_32768");
    run_op(32'd5045, 32'd45042, 32'd0, 1, 0, "p5045");
    run_op(32'd1234567, 32'd3456789, 32'd1, 1, 0, "p1234567");
    run_op(32'h100, 32'h0, 32'd8, 3, 0, "bit8");
    run_op(32'h0, 32'h8000_0000, 32'd31, 8, 0, "bit31");
    run_op(32'h00f0_0000, 32'h0010_0000, 32'd21, 6, 0, "bit21");
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus_if.a = 32'd32768; bus_if.b = 32'd32768; bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.a = 32'd65535; bus_if.b = 32'd0;
    lat = 0;
    while (bus_if.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8 || bus_if.result !== 32'd32) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d res=%0d required 8 32", lat, bus_if.result);
    end
    // req_valid held high through DONE must not be taken.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.req_ready !== 1'b0 || bus_if.resp_valid !== 1'b1 || bus_if.result !== 32'd32) begin
        failures++;
        $display("FAIL b2b_done_hold%0d: got rdy=%0b vld=%0b res=%0d required 0 1 32",
                 i, bus_if.req_ready, bus_if.resp_valid, bus_if.result);
      end
    end
    bus_if.a = 32'd65535; bus_if.b = 32'd65535; bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    checks++;
    if (bus_if.req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_not_on_handshake: got rdy=%0b busy=%0b required 1 0",
               bus_if.req_ready, busy);
    end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    lat = 0;
    while (bus_if.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8 || bus_if.result !== 32'd32) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d res=%0d required 8 32", lat, bus_if.result);
    end
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    check_idle("b2b_release", 32'd32);
    last_res = 32'd32;
  endtask

  task automatic test_backpressure();
    run_op(32'h100, 32'h0, 32'd8, 3, 10, "backpressure");
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    bus_if.a = 32'd0; bus_if.b = 32'd0; bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_idle("flush_scan", last_res);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_no_resp: got %0d valid cycles required 0", seen);
    end
    // flush beats a simultaneous request in IDLE.
    bus_if.a = 32'd1; bus_if.b = 32'd0; bus_if.req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0; flush = 1'b0;
    check_idle("flush_idle_req", last_res);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus_if.a = 32'd0; bus_if.b = 32'h8000_0000; bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset_scan", 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0;
    run_op(32'd1, 32'd0, 32'd0, 1, 0, "after_reset");
  endtask

`ifdef DIFF_SEQ_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd1, 32'd0, 32'd0, 1, 0, "perf_op1");
    run_op(32'h100, 32'h0, 32'd8, 3, 0, "perf_op2");
    run_op(32'd7, 32'd7, 32'd32, 8, 0, "perf_op3");
    checks++;
    if (perf_ops !== 32'd3 || perf_cycles !== 32'd12) begin
      failures++;
      $display("FAIL perf_counts: got ops=%0d cycles=%0d required 3 12", perf_ops, perf_cycles);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    last_res = '0;
    test_reset();
    test_patterns();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef DIFF_SEQ_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/diff_seq_unit.md
Name: diff_seq_unit

Overview:
- Multi-cycle sequencer for the DIFF operation: returns the index of the least-significant bit position where operands a and b differ.
- Scans BITS_PER_CYCLE bits per clock and terminates early on the first hit, so the comparison logic is narrow.
- Sits beside the ALU in the execute stage and is driven by the control unit through valid/ready handshakes on both request and response.
- A stall/flush input lets the pipeline cancel an in-flight operation.

Parameters:
- WIDTH, 32, operand width in bits; must be a power of 2.
- BITS_PER_CYCLE, 4, bits examined per SCAN cycle; must divide WIDTH. N_CHUNKS = WIDTH/BITS_PER_CYCLE.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; forces IDLE and drops any operation or result
- req_valid  input  1  request strobe from the controller
- req_ready  output  1  unit can accept a request
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts the result
- result  output  WIDTH  index of the lowest differing bit, or WIDTH if a == b
- busy  output  1  high in SCAN or DONE

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state = IDLE, req_ready = 1, resp_valid = 0, result = 0, busy = 0.
  - Internal operand registers and chunk index are cleared.
- States are IDLE, SCAN and DONE.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid & req_ready, latch x = a ^ b, set chunk index k = 0, go to SCAN.
- SCAN (req_ready = 0):
  - Each edge examines x[k*B +: B], where B = BITS_PER_CYCLE.
  - If nonzero: result = k*B + (lowest set bit in chunk), go to DONE.
  - Else if k == N_CHUNKS-1: result = WIDTH, go to DONE.
  - Else: k = k+1.
- DONE:
  - resp_valid = 1, and result is held stable until accepted.
  - On an edge with resp_ready = 1: go to IDLE, resp_valid drops to 0.
  - req_ready stays 0 in DONE; a new request is accepted no earlier than the cycle after the handshake.
- Latency, counted in edges from the accept edge to resp_valid high:
  - Hit in chunk k: k+1 edges.
  - a == b: N_CHUNKS edges (8 with the defaults).
- Result encoding:
  - Zero-extended to WIDTH bits; upper bits are always 0.
  - The value WIDTH is reserved as the "no difference" code.
- flush:
  - Has priority over every transition; takes effect at the next edge from any state. resp_valid = 0 and result is unchanged.
  - flush together with req_valid in IDLE: the request is not accepted.
- Back-pressure: resp_ready may be held low indefinitely; the unit stays in DONE with all outputs stable.
- Reset asserted mid-SCAN or mid-DONE: immediate return to reset values; the operation is lost.
- Operands a and b are sampled only on the accept edge; later changes have no effect.

Optional Feature:
- Macro DIFF_SEQ_PERF_EN.
- Defined:
  - Adds output perf_ops [31:0], which counts completed response handshakes.
  - Adds output perf_cycles [31:0], which counts edges spent in SCAN.
  - Both clear on reset, are not cleared by flush, and wrap at 2^32.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- a=1, b=0, resp_ready=1 -> result=0, resp_valid high 1 edge after accept, busy=1 until the response handshake.
- a=32768, b=32768 -> result=32, latency 8 edges; then a=65535, b=65535 -> result=32; no accept while DONE.
- a=5045, b=45042 -> result=0; a=1234567, b=3456789 -> result=1; a=0x100, b=0 -> result=8, latency 3; a=0, b=0x80000000 -> result=31, latency 8.
- Back-pressure: a=0x100, b=0, resp_ready=0 for 10 cycles -> resp_valid stays 1, result stays 8, req_ready stays 0; raise resp_ready -> IDLE next cycle.
- Abort: flush pulsed on the 3rd SCAN cycle of a=b=0 -> IDLE next edge, resp_valid never asserts. Separately, rst_n low mid-SCAN -> outputs go to reset values immediately without a clock edge. A following a=1, b=0 request returns 0.
- With DIFF_SEQ_PERF_EN: the three operations (1,0), (0x100,0), (7,7) -> perf_ops=3, perf_cycles=1+3+8=12.
